// File: rtl/hsv_core_commit.sv
// In-order commit stage: picks the result whose tag matches the expected issue order,
// writes it back, traps on exceptions and drains on flush. Optional macro: HSV_COMMIT_RETIRE_CNT_EN.
module hsv_core_commit #(
  parameter int TAG_W  = 3,
  parameter int NUM_PU = 4
) (
  input  logic                          clk_core,
  input  logic                          rst_core_n,
  input  logic                          flush_req,
  output logic                          flush_ack,
  input  logic [NUM_PU-1:0]             pu_valid_i,
  output logic [NUM_PU-1:0]             pu_ready_o,
  input  logic [NUM_PU-1:0][TAG_W-1:0]  pu_tag,
  input  logic [NUM_PU-1:0][4:0]        pu_rd,
  input  logic [NUM_PU-1:0]             pu_wr,
  input  logic [NUM_PU-1:0][31:0]       pu_value,
  input  logic [NUM_PU-1:0]             pu_exc,
  output logic                          rf_wr_en,
  output logic [4:0]                    rf_rd,
  output logic [31:0]                   rf_data,
  output logic                          trap_o,
  output logic [63:0]                   retired
);

  localparam int IDX_W = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e            state_r;
  state_e            state_nxt_s;
  logic [TAG_W-1:0]  exp_tag_r;
  logic [NUM_PU-1:0] match_s;
  logic              found_s;
  logic [IDX_W-1:0]  sel_s;
  logic              accept_s;
  logic              sel_exc_s;
  logic              commit_s;

  // Tag match per channel; descending scan leaves the lowest matching index selected
  always_comb begin
    match_s = {NUM_PU{1'b0}};
    sel_s   = {IDX_W{1'b0}};
    for (int i = NUM_PU - 1; i >= 0; i--) begin
      match_s[i] = pu_valid_i[i] & (pu_tag[i] == exp_tag_r);
      sel_s      = match_s[i] ? i[IDX_W-1:0] : sel_s;
    end
    found_s   = |match_s;
    sel_exc_s = pu_exc[sel_s];
    commit_s  = accept_s & ~sel_exc_s;
  end

  // Next-state, handshake and flush acknowledge; a same-cycle flush cancels the accept
  always_comb begin
    state_nxt_s = state_r;
    pu_ready_o  = {NUM_PU{1'b0}};
    flush_ack   = 1'b0;
    accept_s    = 1'b0;
    case (state_r)
      RUN: begin
        pu_ready_o[sel_s] = found_s;
        accept_s          = found_s & ~flush_req;
        if (flush_req) begin
          state_nxt_s = FLUSH;
        end else if (accept_s && sel_exc_s) begin
          state_nxt_s = HALT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      HALT: begin
        if (flush_req) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = HALT;
        end
      end
      FLUSH: begin
        pu_ready_o = {NUM_PU{1'b1}};
        flush_ack  = flush_req & ~(|pu_valid_i);
        if (flush_req) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // State register and expected-tag counter (cleared by any flush)
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_r   <= RUN;
      exp_tag_r <= {TAG_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (flush_req || (state_r == FLUSH)) begin
        exp_tag_r <= {TAG_W{1'b0}};
      end else if (accept_s) begin
        exp_tag_r <= exp_tag_r + {{(TAG_W-1){1'b0}}, 1'b1};
      end else begin
        exp_tag_r <= exp_tag_r;
      end
    end
  end

  // Registered write-back port and trap pulse
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      rf_wr_en <= 1'b0;
      rf_rd    <= 5'd0;
      rf_data  <= 32'd0;
      trap_o   <= 1'b0;
    end else begin
      rf_wr_en <= commit_s & pu_wr[sel_s] & (pu_rd[sel_s] != 5'd0);
      trap_o   <= accept_s & sel_exc_s;
      if (commit_s) begin
        rf_rd   <= pu_rd[sel_s];
        rf_data <= pu_value[sel_s];
      end else begin
        rf_rd   <= rf_rd;
        rf_data <= rf_data;
      end
    end
  end

`ifdef HSV_COMMIT_RETIRE_CNT_EN
  logic [63:0] retired_r;

  // Retired-instruction counter; wraps naturally at 2^64
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      retired_r <= 64'd0;
    end else if (commit_s) begin
      retired_r <= retired_r + 64'd1;
    end else begin
      retired_r <= retired_r;
    end
  end

  assign retired = retired_r;
`else
  assign retired = 64'd0;
`endif

endmodule

// File: doc/hsv_core_commit.md
HSV_CORE_COMMIT -- requirements
Module: hsv_core_commit

Interface
REQ-001 SHALL have parameter TAG_W, default 3: width of the issue-order tag.
REQ-002 SHALL have parameter NUM_PU, fixed at 4: result channel count (0 alu, 1 mem, 2 branch, 3 ctrl_status).
REQ-003 SHALL have port clk_core, input, 1: the single clock.
REQ-004 SHALL have port rst_core_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port flush_req, input, 1: pipeline flush request.
REQ-006 SHALL have port flush_ack, output, 1: flush complete.
REQ-007 SHALL have port pu_valid_i, input, [NUM_PU]: result valid per channel.
REQ-008 SHALL have port pu_ready_o, output, [NUM_PU]: result accepted per channel.
REQ-009 SHALL have port pu_tag, input, [NUM_PU][TAG_W]: issue-order tag.
REQ-010 SHALL have port pu_rd, input, [NUM_PU][5]: destination register.
REQ-011 SHALL have port pu_wr, input, [NUM_PU]: result writes rd.
REQ-012 SHALL have port pu_value, input, [NUM_PU][32]: result data.
REQ-013 SHALL have port pu_exc, input, [NUM_PU]: result raises exception.
REQ-014 SHALL have port rf_wr_en, output, 1: register-file write strobe.
REQ-015 SHALL have port rf_rd, output, 5: register-file write address.
REQ-016 SHALL have port rf_data, output, 32: register-file write data.
REQ-017 SHALL have port trap_o, output, 1: one-cycle exception pulse.
REQ-018 SHALL have port retired, output, 64: retired-instruction count.

Function
REQ-019 SHALL implement FSM states RUN, HALT and FLUSH.
REQ-020 In RUN, a channel SHALL be selected when pu_valid_i is set and pu_tag equals the expected-tag counter.
REQ-021 In RUN, the selected channel SHALL get pu_ready_o=1 in the same cycle (combinational); all other channels SHALL get 0.
REQ-022 If several channels match, the lowest index SHALL win; the rest stall.
REQ-023 On accept with pu_exc=0, rf_wr_en/rf_rd/rf_data SHALL be registered with 1-cycle latency.
REQ-024 rf_wr_en SHALL be 1 only if pu_wr=1 and pu_rd!=0.
REQ-025 Each accept SHALL increment the expected tag modulo 2^TAG_W, wrapping from max to 0.
REQ-026 On accept with pu_exc=1:
- no register write;
- trap_o SHALL pulse for 1 cycle (registered);
- the tag SHALL increment;
- FSM SHALL go RUN->HALT.
REQ-027 In HALT, all pu_ready_o SHALL be 0 until flush_req.
REQ-028 flush_req in RUN or HALT SHALL go to FLUSH the next cycle and SHALL override any same-cycle accept (no write, no trap).
REQ-029 In FLUSH:
- all pu_ready_o SHALL be 1, draining and discarding inputs;
- the expected tag SHALL be forced to 0.
REQ-030 In FLUSH, flush_ack SHALL be 1 while flush_req=1 and no pu_valid_i is set.
REQ-031 FLUSH->RUN SHALL occur on the cycle after flush_req falls.

Reset
REQ-032 On rst_core_n low, asynchronously:
- FSM=RUN and expected tag=0;
- rf_wr_en, rf_rd, rf_data, trap_o and flush_ack=0;
- retired=0.
REQ-033 Reset mid-operation SHALL discard any pending write or trap.

Configuration
REQ-034 Macro HSV_COMMIT_RETIRE_CNT_EN defined: retired SHALL increment by 1 on each non-exception accept; it SHALL wrap at 2^64 and hold during FLUSH.
REQ-035 Macro HSV_COMMIT_RETIRE_CNT_EN undefined: retired SHALL be constant 0 and no counter flops are built.

Verification
REQ-036 In-order: ch1 tag0 then ch0 tag1, both valid in cycle 0, rd=3/4. Required: ch1 writes rd3 in cycle 1, ch0 writes rd4 in cycle 2.
REQ-037 Out-of-order hold: ch2 tag1 valid and expected=0. Required: pu_ready_o[2]=0 until ch0 tag0 accepts.
REQ-038 Wrap, TAG_W=3: 9 sequential accepts tags 0..7,0. Required: all commit; expected tag=1 after.
REQ-039 Exception: ch3 tag0 with pu_exc=1. Required: trap_o=1 one cycle later, rf_wr_en=0, HALT, then flush_req.
REQ-040 Flush: flush_req while ch0 tag5 and ch1 tag6 valid. Required: both drained, flush_ack=1 once both drop, next accept needs tag 0.
REQ-041 rd0 / counter: accept rd=0 pu_wr=1. Required: rf_wr_en=0; retired+1 with macro, 0 without.
